// File: rtl/rename_commit_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rename_commit_ctrl_pkg : shared types and encodings for rename_commit_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rename_commit_ctrl_pkg;

  // Rollback port encodings, ordered {DO_REL, DO_ROLL}
  localparam logic [1:0] c_ROLLBK_REL     = 2'b10;
  localparam logic [1:0] c_ROLLBK_RESTORE = 2'b01;

  // Per-entry status; name and checkpoint id live in width-parameterised arrays beside it
  typedef struct packed {
    logic valid;
    logic done;
    logic chk;
  } rcc_entry_t;

  function automatic int rcc_tag_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rename_commit_ctrl_age_cmp.sv
// ----------------------------------------------------------------------------
// rcc_age_cmp : is a candidate tag in flight and younger than a reference tag
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rcc_age_cmp #(
  parameter int TAG_WIDTH = 3
) (
  input  logic [TAG_WIDTH:0]   i_head,
  input  logic [TAG_WIDTH:0]   i_tail,
  input  logic [TAG_WIDTH-1:0] i_ref_tag,
  input  logic [TAG_WIDTH-1:0] i_cand_tag,
  output logic                 o_younger
);

  logic [TAG_WIDTH:0]   w_count;
  logic [TAG_WIDTH-1:0] w_cand_age;
  logic [TAG_WIDTH-1:0] w_ref_age;

  // Ages are distances from the head, taken modulo the queue depth
  assign w_count    = i_tail - i_head;
  assign w_cand_age = i_cand_tag - i_head[TAG_WIDTH-1:0];
  assign w_ref_age  = i_ref_tag - i_head[TAG_WIDTH-1:0];

  assign o_younger = (w_cand_age > w_ref_age) && ({1'b0, w_cand_age} < w_count);

endmodule

`default_nettype wire

// File: rtl/rename_commit_ctrl.sv
// ----------------------------------------------------------------------------
// rename_commit_ctrl : in-order commit and mispredict recovery sequencer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rename_commit_ctrl
  import rename_commit_ctrl_pkg::*;
#(
  parameter int name_width    = 1,
  parameter int replica_width = 1,
  parameter int depth         = 8,
  parameter int tag_width     = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENQ_E,
  input  logic [name_width-1:0]    ENQ_NAME,
  input  logic                     ENQ_CHK,
  input  logic [replica_width-1:0] ENQ_CHK_ID,
  output logic                     ENQ_READY,
  output logic [tag_width-1:0]     ENQ_TAG,
  input  logic                     DONE_E_1,
  input  logic                     DONE_E_2,
  input  logic [tag_width-1:0]     DONE_TAG_1,
  input  logic [tag_width-1:0]     DONE_TAG_2,
  input  logic                     MISP_E,
  input  logic [tag_width-1:0]     MISP_TAG,
  output logic                     FE,
  output logic [name_width-1:0]    NAME_F,
  output logic                     ROLLBK_E,
  output logic                     DO_ROLL,
  output logic                     DO_REL,
  output logic [replica_width-1:0] ROLLBK_IN,
  output logic                     CHK_BLOCK,
  output logic                     EMPTY
);

  localparam int                 c_PTR_W    = tag_width + 1;
  localparam logic [tag_width:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [tag_width-1:0] c_LAST_IDX = tag_width'(depth - 1);

  if (tag_width != rcc_tag_width(depth)) begin : g_param_check
    $error("rename_commit_ctrl: tag_width must equal log2(depth)");
  end

  logic [tag_width:0]       r_head;
  logic [tag_width:0]       r_tail;
  rcc_entry_t               w_ent    [depth];
  logic [name_width-1:0]    w_name   [depth];
  logic [replica_width-1:0] w_chk_id [depth];
  logic [depth-1:0]         w_younger;

  logic [tag_width-1:0] w_head_idx;
  logic [tag_width-1:0] w_tail_idx;
  rcc_entry_t           w_head_ent;
  logic                 w_full;
  logic                 w_misp;
  logic                 w_commit;
  logic                 w_enq;
  logic                 w_misp_past_wrap;
  logic [tag_width:0]   w_misp_ptr;
  logic [tag_width:0]   w_new_tail;

  assign w_head_idx = r_head[tag_width-1:0];
  assign w_tail_idx = r_tail[tag_width-1:0];
  assign w_head_ent = w_ent[w_head_idx];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[tag_width] != r_tail[tag_width]);

  // Strobes are held off while in reset so a mid-flight reset is silent to the file
  assign w_misp   = MISP_E & ~RST;
  assign w_commit = ~RST & ~MISP_E & w_head_ent.valid & w_head_ent.done;
  assign w_enq    = ENQ_E & ENQ_READY;

  assign EMPTY     = (r_head == r_tail);
  assign ENQ_TAG   = w_tail_idx;
  assign ENQ_READY = ~w_full & ~ROLLBK_E;
  assign CHK_BLOCK = ROLLBK_E;
  assign FE        = w_commit;
  assign NAME_F    = w_commit ? w_name[w_head_idx] : '0;

  always_comb begin
    ROLLBK_E  = 1'b0;
    DO_ROLL   = 1'b0;
    DO_REL    = 1'b0;
    ROLLBK_IN = '0;
    if (w_misp) begin
      ROLLBK_E          = 1'b1;
      {DO_REL, DO_ROLL} = c_ROLLBK_RESTORE;
      ROLLBK_IN         = w_chk_id[MISP_TAG];
    end else if (w_commit && w_head_ent.chk) begin
      ROLLBK_E          = 1'b1;
      {DO_REL, DO_ROLL} = c_ROLLBK_REL;
      ROLLBK_IN         = w_chk_id[w_head_idx];
    end
  end

  // A mispredicted tag past the last index (in age order) sits one lap beyond the head
  rcc_age_cmp #(.TAG_WIDTH(tag_width)) u_wrap_cmp (
    .i_head     (r_head),
    .i_tail     (r_tail),
    .i_ref_tag  (c_LAST_IDX),
    .i_cand_tag (MISP_TAG),
    .o_younger  (w_misp_past_wrap)
  );

  assign w_misp_ptr = {r_head[tag_width] ^ w_misp_past_wrap, MISP_TAG};
  assign w_new_tail = w_misp_ptr + c_PTR_ONE;

  for (genvar gi = 0; gi < depth; gi++) begin : g_entry
    localparam logic [tag_width-1:0] c_IDX = tag_width'(gi);

    rcc_entry_t               r_ent;
    logic [name_width-1:0]    r_name;
    logic [replica_width-1:0] r_chk_id;
    logic                     w_done_hit;

    assign w_done_hit = (DONE_E_1 && (DONE_TAG_1 == c_IDX)) ||
                        (DONE_E_2 && (DONE_TAG_2 == c_IDX));

    rcc_age_cmp #(.TAG_WIDTH(tag_width)) u_squash_cmp (
      .i_head     (r_head),
      .i_tail     (r_tail),
      .i_ref_tag  (MISP_TAG),
      .i_cand_tag (c_IDX),
      .o_younger  (w_younger[gi])
    );

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_ent    <= '0;
        r_name   <= '0;
        r_chk_id <= '0;
      end else if (w_enq && (w_tail_idx == c_IDX)) begin
        r_ent    <= '{valid: 1'b1, done: 1'b0, chk: ENQ_CHK};
        r_name   <= ENQ_NAME;
        r_chk_id <= ENQ_CHK_ID;
      end else begin
        if (r_ent.valid && w_done_hit)
          r_ent.done <= 1'b1;
        if ((w_misp && w_younger[gi]) || (w_commit && (w_head_idx == c_IDX)))
          r_ent.valid <= 1'b0;
      end
    end

    assign w_ent[gi]    = r_ent;
    assign w_name[gi]   = r_name;
    assign w_chk_id[gi] = r_chk_id;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_commit)
        r_head <= r_head + c_PTR_ONE;
      if (w_misp)
        r_tail <= w_new_tail;
      else if (w_enq)
        r_tail <= r_tail + c_PTR_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rename_commit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rename_commit_ctrl : directed self-checking bench for rename_commit_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rename_commit_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ENQ_E;
  logic [3:0] ENQ_NAME;
  logic       ENQ_CHK;
  logic [0:0] ENQ_CHK_ID;
  logic       ENQ_READY;
  logic [2:0] ENQ_TAG;
  logic       DONE_E_1, DONE_E_2;
  logic [2:0] DONE_TAG_1, DONE_TAG_2;
  logic       MISP_E;
  logic [2:0] MISP_TAG;
  logic       FE;
  logic [3:0] NAME_F;
  logic       ROLLBK_E, DO_ROLL, DO_REL;
  logic [0:0] ROLLBK_IN;
  logic       CHK_BLOCK;
  logic       EMPTY;

  int checks   = 0;
  int failures = 0;

  rename_commit_ctrl #(
    .name_width(4), .replica_width(1), .depth(8), .tag_width(3)
  ) dut (
    .CLK(CLK), .RST(RST),
    .ENQ_E(ENQ_E), .ENQ_NAME(ENQ_NAME), .ENQ_CHK(ENQ_CHK), .ENQ_CHK_ID(ENQ_CHK_ID),
    .ENQ_READY(ENQ_READY), .ENQ_TAG(ENQ_TAG),
    .DONE_E_1(DONE_E_1), .DONE_E_2(DONE_E_2), .DONE_TAG_1(DONE_TAG_1), .DONE_TAG_2(DONE_TAG_2),
    .MISP_E(MISP_E), .MISP_TAG(MISP_TAG),
    .FE(FE), .NAME_F(NAME_F),
    .ROLLBK_E(ROLLBK_E), .DO_ROLL(DO_ROLL), .DO_REL(DO_REL), .ROLLBK_IN(ROLLBK_IN),
    .CHK_BLOCK(CHK_BLOCK), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ENQ_E = 0; ENQ_NAME = 0; ENQ_CHK = 0; ENQ_CHK_ID = 0;
    DONE_E_1 = 0; DONE_E_2 = 0; DONE_TAG_1 = 0; DONE_TAG_2 = 0;
    MISP_E = 0; MISP_TAG = 0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    tick();
    tick();
    RST = 0;
    #1;
  endtask

  task automatic enq(input logic [3:0] nm, input logic chk, input logic id);
    ENQ_E = 1; ENQ_NAME = nm; ENQ_CHK = chk; ENQ_CHK_ID = id;
    tick();
    ENQ_E = 0; ENQ_CHK = 0; ENQ_CHK_ID = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL reset_empty: got %0b want 1", EMPTY); end
    checks++; if (ENQ_READY !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", ENQ_READY); end
    checks++; if (ENQ_TAG !== 3'd0) begin failures++; $display("FAIL reset_tag: got %0d want 0", ENQ_TAG); end
    checks++; if ({FE, ROLLBK_E, DO_ROLL, DO_REL, CHK_BLOCK} !== 5'b0) begin failures++;
      $display("FAIL reset_strobes: got %b want 00000", {FE, ROLLBK_E, DO_ROLL, DO_REL, CHK_BLOCK}); end
    checks++; if (NAME_F !== 4'd0) begin failures++; $display("FAIL reset_name_f: got %0d want 0", NAME_F); end
    checks++; if (ROLLBK_IN !== 1'b0) begin failures++; $display("FAIL reset_rollbk_in: got %0d want 0", ROLLBK_IN); end
  endtask

  task automatic test_inorder_commit();
    do_reset();
    enq(5, 0, 0);
    enq(6, 0, 0);
    checks++; if (ENQ_TAG !== 3'd2) begin failures++; $display("FAIL inorder_tag2: got %0d want 2", ENQ_TAG); end
    enq(7, 0, 0);
    DONE_E_1 = 1; DONE_TAG_1 = 1; #1;
    checks++; if (FE !== 1'b0) begin failures++; $display("FAIL inorder_fe_idle: got %0b want 0", FE); end
    tick();
    DONE_TAG_1 = 0; #1;
    checks++; if (FE !== 1'b0) begin failures++; $display("FAIL inorder_no_early_fe: got %0b want 0", FE); end
    tick();
    DONE_TAG_1 = 2; #1;
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd5) begin failures++; $display("FAIL inorder_c0: got fe=%0b name=%0d want fe=1 name=5", FE, NAME_F); end
    tick();
    idle(); #1;
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd6) begin failures++; $display("FAIL inorder_c1: got fe=%0b name=%0d want fe=1 name=6", FE, NAME_F); end
    tick();
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd7) begin failures++; $display("FAIL inorder_c2: got fe=%0b name=%0d want fe=1 name=7", FE, NAME_F); end
    tick();
    checks++; if (FE !== 1'b0 || EMPTY !== 1'b1) begin failures++; $display("FAIL inorder_drained: got fe=%0b empty=%0b want fe=0 empty=1", FE, EMPTY); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) enq(4'(i + 1), 0, 0);
    checks++; if (ENQ_READY !== 1'b0) begin failures++; $display("FAIL full_ready: got %0b want 0", ENQ_READY); end
    DONE_E_1 = 1; DONE_TAG_1 = 0;
    tick();
    idle();
    ENQ_E = 1; ENQ_NAME = 15; #1;
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd1) begin failures++; $display("FAIL full_commit: got fe=%0b name=%0d want fe=1 name=1", FE, NAME_F); end
    checks++; if (ENQ_READY !== 1'b0) begin failures++; $display("FAIL full_refuse_same_cycle: got %0b want 0", ENQ_READY); end
    tick();
    ENQ_E = 0; #1;
    checks++; if (ENQ_READY !== 1'b1) begin failures++; $display("FAIL full_ready_after: got %0b want 1", ENQ_READY); end
    checks++; if (ENQ_TAG !== 3'd0) begin failures++; $display("FAIL full_tag_wrap: got %0d want 0", ENQ_TAG); end
    enq(9, 0, 0);
    checks++; if (ENQ_READY !== 1'b0) begin failures++; $display("FAIL full_again: got %0b want 0", ENQ_READY); end
  endtask

  task automatic test_mispredict();
    do_reset();
    enq(1, 0, 0);
    enq(2, 0, 0);
    enq(3, 1, 1);
    enq(4, 0, 0);
    enq(5, 0, 0);
    MISP_E = 1; MISP_TAG = 2;
    DONE_E_1 = 1; DONE_TAG_1 = 1; DONE_E_2 = 1; DONE_TAG_2 = 3; #1;
    checks++; if ({ROLLBK_E, DO_ROLL, DO_REL} !== 3'b110) begin failures++;
      $display("FAIL misp_strobes: got %b want 110", {ROLLBK_E, DO_ROLL, DO_REL}); end
    checks++; if (ROLLBK_IN !== 1'b1) begin failures++; $display("FAIL misp_rollbk_in: got %0d want 1", ROLLBK_IN); end
    checks++; if (CHK_BLOCK !== 1'b1 || ENQ_READY !== 1'b0) begin failures++;
      $display("FAIL misp_block: got chk_block=%0b ready=%0b want 1 0", CHK_BLOCK, ENQ_READY); end
    tick();
    idle(); #1;
    checks++; if (ENQ_TAG !== 3'd3) begin failures++; $display("FAIL misp_new_tag: got %0d want 3", ENQ_TAG); end
    checks++; if (ROLLBK_E !== 1'b0) begin failures++; $display("FAIL misp_one_shot: got %0b want 0", ROLLBK_E); end
    DONE_E_1 = 1; DONE_TAG_1 = 0;
    tick();
    idle(); #1;
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd1) begin failures++; $display("FAIL misp_c0: got fe=%0b name=%0d want fe=1 name=1", FE, NAME_F); end
    tick();
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd2) begin failures++; $display("FAIL misp_survivor_done: got fe=%0b name=%0d want fe=1 name=2", FE, NAME_F); end
    tick();
    checks++; if (FE !== 1'b0 || EMPTY !== 1'b0) begin failures++; $display("FAIL misp_chk_wait: got fe=%0b empty=%0b want 0 0", FE, EMPTY); end
    enq(10, 0, 0);
    DONE_E_1 = 1; DONE_TAG_1 = 2; DONE_E_2 = 1; DONE_TAG_2 = 3;
    tick();
    idle(); #1;
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd3) begin failures++; $display("FAIL misp_chk_commit: got fe=%0b name=%0d want fe=1 name=3", FE, NAME_F); end
    checks++; if ({ROLLBK_E, DO_REL, DO_ROLL} !== 3'b110 || ROLLBK_IN !== 1'b1) begin failures++;
      $display("FAIL misp_release: got e/rel/roll=%b in=%0d want 110 in=1", {ROLLBK_E, DO_REL, DO_ROLL}, ROLLBK_IN); end
    checks++; if (ENQ_READY !== 1'b0) begin failures++; $display("FAIL misp_release_ready: got %0b want 0", ENQ_READY); end
    tick();
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd10) begin failures++; $display("FAIL misp_refill: got fe=%0b name=%0d want fe=1 name=10", FE, NAME_F); end
    tick();
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL misp_drained: got %0b want 1", EMPTY); end
  endtask

  task automatic test_misp_vs_commit();
    do_reset();
    enq(4, 1, 0);
    enq(5, 0, 0);
    DONE_E_1 = 1; DONE_TAG_1 = 0;
    tick();
    idle();
    MISP_E = 1; MISP_TAG = 0; #1;
    checks++; if (FE !== 1'b0) begin failures++; $display("FAIL mvc_commit_stalled: got %0b want 0", FE); end
    checks++; if ({ROLLBK_E, DO_ROLL, DO_REL} !== 3'b110 || ROLLBK_IN !== 1'b0) begin failures++;
      $display("FAIL mvc_restore: got e/roll/rel=%b in=%0d want 110 in=0", {ROLLBK_E, DO_ROLL, DO_REL}, ROLLBK_IN); end
    tick();
    MISP_E = 0; #1;
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd4) begin failures++; $display("FAIL mvc_commit_next: got fe=%0b name=%0d want fe=1 name=4", FE, NAME_F); end
    checks++; if ({ROLLBK_E, DO_REL, DO_ROLL} !== 3'b110 || ROLLBK_IN !== 1'b0) begin failures++;
      $display("FAIL mvc_release_id0: got e/rel/roll=%b in=%0d want 110 in=0", {ROLLBK_E, DO_REL, DO_ROLL}, ROLLBK_IN); end
    tick();
    checks++; if (EMPTY !== 1'b1 || FE !== 1'b0) begin failures++; $display("FAIL mvc_squashed: got empty=%0b fe=%0b want 1 0", EMPTY, FE); end
  endtask

  task automatic test_misp_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) enq(4'(i + 1), 0, 0);
    DONE_E_1 = 1; DONE_E_2 = 1;
    DONE_TAG_1 = 0; DONE_TAG_2 = 1; tick();
    DONE_TAG_1 = 2; DONE_TAG_2 = 3; tick();
    DONE_TAG_1 = 4; DONE_TAG_2 = 5; tick();
    idle();
    repeat (6) tick();
    checks++; if (EMPTY !== 1'b1 || ENQ_TAG !== 3'd6) begin failures++; $display("FAIL wrap_prefill: got empty=%0b tag=%0d want 1 6", EMPTY, ENQ_TAG); end
    enq(1, 0, 0);
    enq(2, 1, 1);
    enq(3, 1, 0);
    enq(4, 0, 0);
    MISP_E = 1; MISP_TAG = 0;
    DONE_E_1 = 1; DONE_TAG_1 = 6; DONE_E_2 = 1; DONE_TAG_2 = 7;
    tick();
    idle(); #1;
    checks++; if (ENQ_TAG !== 3'd1) begin failures++; $display("FAIL wrap_new_tag: got %0d want 1", ENQ_TAG); end
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd1) begin failures++; $display("FAIL wrap_c6: got fe=%0b name=%0d want fe=1 name=1", FE, NAME_F); end
    DONE_E_1 = 1; DONE_TAG_1 = 0;
    tick();
    idle(); #1;
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd2 || ROLLBK_IN !== 1'b1) begin failures++;
      $display("FAIL wrap_c7: got fe=%0b name=%0d in=%0d want fe=1 name=2 in=1", FE, NAME_F, ROLLBK_IN); end
    tick();
    checks++; if (FE !== 1'b1 || NAME_F !== 4'd3) begin failures++; $display("FAIL wrap_c0: got fe=%0b name=%0d want fe=1 name=3", FE, NAME_F); end
    tick();
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL wrap_tail_wrapbit: got empty=%0b want 1", EMPTY); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) enq(4'(i + 1), 0, 0);
    DONE_E_1 = 1; DONE_TAG_1 = 0;
    tick();
    idle();
    RST = 1; #1;
    checks++; if (FE !== 1'b0 || ROLLBK_E !== 1'b0) begin failures++; $display("FAIL rstmid_quiet: got fe=%0b rollbk=%0b want 0 0", FE, ROLLBK_E); end
    tick();
    RST = 0; #1;
    checks++; if (EMPTY !== 1'b1 || FE !== 1'b0 || ENQ_TAG !== 3'd0) begin failures++;
      $display("FAIL rstmid_cleared: got empty=%0b fe=%0b tag=%0d want 1 0 0", EMPTY, FE, ENQ_TAG); end
    DONE_E_1 = 1; DONE_TAG_1 = 2;
    tick();
    idle(); #1;
    checks++; if (EMPTY !== 1'b1 || FE !== 1'b0) begin failures++; $display("FAIL rstmid_late_done: got empty=%0b fe=%0b want 1 0", EMPTY, FE); end
  endtask

  initial begin
    idle();
    RST = 1;
    test_reset();
    test_inorder_commit();
    test_full_wrap();
    test_mispredict();
    test_misp_vs_commit();
    test_misp_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
